// File: rtl/stopwatch_ctrl.sv
// Stopwatch control: key sync/edge detect, run/pause/lap FSM,
// tick prescaler and display mux for a 3-digit BCD counter.
module stopwatch_ctrl #(
  parameter int TICK_DIV = 1000000,
  parameter bit WRAP_EN  = 1'b0
) (
  input  logic       clock,
  input  logic       reset,
  input  logic       key_start_n,
  input  logic       key_lap_n,
  input  logic       key_clear_n,
  input  logic [3:0] bcd0,
  input  logic [3:0] bcd1,
  input  logic [3:0] bcd2,
  output logic       count_en,
  output logic       count_clr,
  output logic [3:0] disp0,
  output logic [3:0] disp1,
  output logic [3:0] disp2,
  output logic [2:0] state
);

  localparam int CW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  localparam logic [CW-1:0] LAST = CW'(TICK_DIV - 1);

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    RUN   = 3'd1,
    PAUSE = 3'd2,
    LAP   = 3'd3,
    DONE  = 3'd4
  } state_e;

  // key vectors: [0]=start, [1]=lap, [2]=clear
  logic [2:0] sync1_q, sync1_d;
  logic [2:0] sync2_q, sync2_d;
  logic [2:0] prev_q, prev_d;
  logic [2:0] press;

  state_e         state_q, state_d;
  logic [CW-1:0]  pre_q, pre_d;
  logic [11:0]    lap_q, lap_d;
  logic           clr_q, clr_d;

  logic [11:0] bcd_all;
  logic        clr_p, start_p, lap_p;
  logic        running, at_last, hold999, tick;

  assign bcd_all = {bcd2, bcd1, bcd0};
  assign press   = ~sync2_q & prev_q;
  assign clr_p   = press[2];
  assign start_p = press[0] & ~press[2];
  assign lap_p   = press[1] & ~press[0] & ~press[2];

  assign running = (state_q == RUN) || (state_q == LAP);
  assign at_last = (pre_q == LAST);
  assign hold999 = !WRAP_EN && (bcd_all == 12'h999);
  assign tick    = running && at_last;

  assign count_en  = tick && !hold999 && !reset;
  assign count_clr = clr_q;
  assign state     = state_q;
  assign {disp2, disp1, disp0} = (state_q == LAP) ? lap_q : bcd_all;

  always_comb begin
    sync1_d = {key_clear_n, key_lap_n, key_start_n};
    sync2_d = sync1_q;
    prev_d  = sync2_q;
    state_d = state_q;
    lap_d   = lap_q;
    clr_d   = 1'b0;
    case (state_q)
      RUN, LAP: pre_d = at_last ? '0 : pre_q + 1'b1;
      PAUSE:    pre_d = pre_q;
      default:  pre_d = '0;
    endcase
    if (tick && hold999) state_d = DONE;
    // a press in the same cycle overrides the move to DONE
    unique case (1'b1)
      clr_p: begin
        state_d = IDLE;
        pre_d   = '0;
        clr_d   = 1'b1;
      end
      start_p: begin
        case (state_q)
          IDLE, PAUSE: state_d = RUN;
          RUN, LAP:    state_d = PAUSE;
          default:     ;
        endcase
      end
      lap_p: begin
        case (state_q)
          RUN: begin
            state_d = LAP;
            lap_d   = bcd_all;
          end
          LAP:     state_d = RUN;
          default: ;
        endcase
      end
      default: ;
    endcase
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      sync1_q <= 3'b111;
      sync2_q <= 3'b111;
      prev_q  <= 3'b111;
      state_q <= IDLE;
      pre_q   <= '0;
      lap_q   <= '0;
      clr_q   <= 1'b0;
    end else begin
      sync1_q <= sync1_d;
      sync2_q <= sync2_d;
      prev_q  <= prev_d;
      state_q <= state_d;
      pre_q   <= pre_d;
      lap_q   <= lap_d;
      clr_q   <= clr_d;
    end
  end

endmodule

// File: doc/stopwatch_ctrl.md
STOPWATCH_CTRL -- requirements
Module: stopwatch_ctrl

Interface
REQ-001 SHALL have parameter TICK_DIV, default 1000000, clock cycles per count tick; legal range 2..2^26.
REQ-002 SHALL have parameter WRAP_EN, default 0, where 1 means wrap 999->000 and 0 means stop at 999.
REQ-003 SHALL have port clock, input, 1 bit, the single clock; all state updates on its rising edge.
REQ-004 SHALL have port reset, input, 1 bit, asynchronous and active-high.
REQ-005 SHALL have port key_start_n, input, 1 bit, raw active-low start/stop button, asynchronous to clock.
REQ-006 SHALL have port key_lap_n, input, 1 bit, raw active-low lap button, asynchronous to clock.
REQ-007 SHALL have port key_clear_n, input, 1 bit, raw active-low clear button, asynchronous to clock.
REQ-008 SHALL have ports bcd0, bcd1 and bcd2, each input, 4 bits, the live BCD digits from the 3-digit counter.
REQ-009 SHALL have port count_en, output, 1 bit, a one-cycle increment strobe to the counter.
REQ-010 SHALL have port count_clr, output, 1 bit, a one-cycle synchronous clear strobe to the counter.
REQ-011 SHALL have ports disp0, disp1 and disp2, each output, 4 bits, the digits sent to the 7-segment decoders.
REQ-012 SHALL have port state, output, 3 bits, encoded IDLE=0, RUN=1, PAUSE=2, LAP=3, DONE=4.

Function
REQ-013 SHALL pass each key through a 2-flop synchronizer and a previous-value flop; a press is sync2=0 while prev=1, one cycle per falling edge.
REQ-014 SHALL update state on the second rising edge after sync1 first samples a low key.
REQ-015 SHALL, when several presses coincide in one cycle, act on clear first, then start, then lap; lower-priority presses are dropped.
REQ-016 SHALL apply these transitions in IDLE: start goes to RUN; clear stays in IDLE and pulses count_clr; lap is ignored.
REQ-017 SHALL apply these transitions in RUN: start goes to PAUSE; lap goes to LAP and latches bcd0..2 into the lap registers on that edge; clear goes to IDLE with count_clr.
REQ-018 SHALL apply these transitions in LAP: lap goes to RUN; start goes to PAUSE; clear goes to IDLE with count_clr.
REQ-019 SHALL apply these transitions in PAUSE: start goes to RUN; lap is ignored; clear goes to IDLE with count_clr.
REQ-020 SHALL apply these transitions in DONE: clear goes to IDLE with count_clr; start and lap are ignored.
REQ-021 SHALL run a prescaler 0..TICK_DIV-1 that advances only in RUN or LAP, holds its value in PAUSE, and is zeroed in IDLE and DONE and on any clear.
REQ-022 SHALL assert count_en combinationally when the prescaler equals TICK_DIV-1, state is RUN or LAP, and the hold-at-999 condition is false; the prescaler wraps to 0 on that cycle.
REQ-023 SHALL treat hold-at-999 as WRAP_EN=0 and bcd2..0=9,9,9; a terminal tick with hold-at-999 true SHALL move the state to DONE with count_en=0.
REQ-024 SHALL, when a terminal tick and a press coincide, evaluate count_en from the pre-edge state, then apply the press transition; clear overrides the move to DONE.
REQ-025 SHALL register count_clr so it is high for exactly the one cycle following the clear edge.
REQ-026 SHALL drive disp0..2 from the lap registers in LAP and from bcd0..2 in every other state, combinationally.
REQ-027 SHALL keep the lap registers unchanged outside the RUN-to-LAP edge.

Reset
REQ-028 SHALL, on reset, set state=IDLE, prescaler=0, lap registers=0, count_clr=0, and all synchronizer and prev flops=1 so no press is generated when reset releases.
REQ-029 SHALL force count_en=0 while reset is high.
REQ-030 SHALL, on reset mid-RUN, abandon the tick in progress without issuing count_clr; the counter keeps its value until a clear press.

Verification (TICK_DIV=4)
REQ-031 SHALL show that after reset and a start press, count_en pulses every 4th cycle, with the first pulse 4 cycles after RUN is entered.
REQ-032 SHALL show, for RUN with bcd=1,2,3, a lap press, then bcd changing to 1,2,4: disp holds 1,2,3 with state=3; a second lap press gives disp=1,2,4 with state=1.
REQ-033 SHALL show that after PAUSE entered with the prescaler at 2, a resume start press gives a count_en pulse after 1 cycle in RUN.
REQ-034 SHALL show, with WRAP_EN=0, bcd=9,9,9 and RUN, that the terminal tick produces count_en=0 and state=4, that start is ignored, and that clear gives state=0 with one count_clr pulse.
REQ-035 SHALL show that start and clear pressed in the same cycle in RUN give state=IDLE, count_clr=1 for one cycle, and no PAUSE.
REQ-036 SHALL show that a key held low for 1000 cycles produces exactly one state transition.
